alu_operand_issue: RTL and testbench
====================================

// Module: alu_operand_issue
// PURPOSE
//  Issue/writeback stage wrapped around the arithmetic unit. Accepts one ALU instruction
//  per valid/ready handshake, reads A/B from an internal register file, drives A, B, C_in
//  and sel to the arithmetic unit, then captures G_out/C_out into the destination register
//  and the carry flag. Sits between the instruction decoder and the arithmetic unit.
// PARAMETERS
//  DATA_W     4  operand/result width; must equal the arithmetic unit's data width
//  REG_COUNT  4  register-file entries, power of two; REG_AW = $clog2(REG_COUNT)
//  SEL_W      2  width of the arithmetic-unit select field
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       synchronous, active-high reset
//  instr_valid in   1       instruction present
//  instr_ready out  1       stage can accept an instruction
//  instr_sel   in   SEL_W   passed to the arithmetic unit's sel
//  instr_rd    in   REG_AW  destination register index
//  instr_ra    in   REG_AW  source A register index
//  instr_rb    in   REG_AW  source B register index
//  instr_usec  in   1       1: C_in = carry flag; 0: C_in = 0
//  alu_a       out  DATA_W  to arithmetic unit A
//  alu_b       out  DATA_W  to arithmetic unit B
//  alu_cin     out  1       to arithmetic unit C_in
//  alu_sel     out  SEL_W   to arithmetic unit sel
//  alu_g       in   DATA_W  from arithmetic unit G_out
//  alu_cout    in   1       from arithmetic unit C_out
//  done        out  1       one-cycle pulse on writeback
//  c_flag      out  1       registered carry flag
//  rd_dbg_idx  in   REG_AW  debug read index
//  rd_dbg_data out  DATA_W  combinational read of register rd_dbg_idx
// BEHAVIOUR
//  - Reset: state=IDLE; all registers, c_flag, alu_a/alu_b/alu_cin/alu_sel, done = 0; instr_ready=1.
//  - FSM IDLE -> ISSUE -> WB -> IDLE. instr_ready = (state==IDLE); accept on valid&&ready.
//  - Cycle 0 (IDLE, accept): latch rd/sel/usec; register alu_a=R[ra], alu_b=R[rb],
//    alu_sel=sel, alu_cin=usec ? c_flag : 0.
//  - Cycle 1 (ISSUE): operands stable; arithmetic unit settles; no state writes.
//  - Cycle 2 (WB): R[rd] <= alu_g; c_flag <= alu_cout; done=1 this cycle; -> IDLE.
//  - Throughput: one instruction per 3 cycles; next accept earliest cycle 3.
//  - Operand outputs hold their value after WB until the next accept.
//  - ra==rb or rd==ra/rb: operands read at accept, so the old value is used; WB wins.
//  - Reads at accept see the previous instruction's writeback (WB precedes next accept).
//  - Width: result is truncated to DATA_W; carry-out goes only to c_flag.
//  - instr_valid while not ready: ignored, no side effects; upstream holds fields.
//  - rst in any state: aborts in-flight instruction, no writeback, done=0 next cycle.
//  - rd_dbg_data reflects a WB write from the cycle after WB.
// CONFIGURATION
//  - ZERO_FLAG_EN defined: extra port z_flag out 1; reset 0; in WB z_flag <= (alu_g==0);
//    otherwise holds.
//  - ZERO_FLAG_EN undefined: no z_flag port, no zero-detect logic.
// STRUCTURE
//  - Package alu_issue_pkg: state enum {IDLE, ISSUE, WB}; SEL_ZERO=2'b00, SEL_B=2'b01,
//    SEL_NOTB=2'b10, SEL_ONES=2'b11; default DATA_W/REG_COUNT constants.
//  - Sub-module alu_regfile: REG_COUNT x DATA_W, two combinational read ports + debug
//    read port, one synchronous write port, synchronous reset to 0.
//  - Top: FSM, operand/issue registers, flag registers.
// TESTING  (DATA_W=4, REG_COUNT=4; arithmetic unit instantiated as DUT partner)
//  - Reset: assert rst 2 cycles mid-ISSUE -> registers 0, c_flag 0, done never pulses, ready=1.
//  - Add: preload R1=3, R2=5 (via prior ops), sel=01 ra=1 rb=2 rd=3 usec=0
//    -> done at cycle 2, R3=8, c_flag=0.
//  - Carry chain: R1=0xF, R2=0x1, usec=0 rd=0 -> R0=0x0, c_flag=1; then ra=1 rb=2 rd=3
//    usec=1 -> R3=0x1, alu_cin=1.
//  - Backpressure: hold instr_valid high for 6 cycles -> exactly 2 accepts, ready low
//    in ISSUE/WB, 2 done pulses.
//  - Hazard: rd=ra=rb=1 with R1=7, usec=0 -> R1=0xE; next instruction reads 0xE.
//  - ZERO_FLAG_EN: result 0x0 -> z_flag=1; following nonzero result -> z_flag=0.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU operand issue / writeback stage.
// The optional zero flag is enabled by defining ZERO_FLAG_EN.
package alu_issue_pkg;

  localparam int DATA_W_DEF    = 4;
  localparam int REG_COUNT_DEF = 4;
  localparam int SEL_W_DEF     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_e;

  // Arithmetic-unit B-path selections
  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_NOTB = 2'b10;
  localparam logic [1:0] SEL_ONES = 2'b11;

endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational operand read ports, one debug read port,
// one synchronous write port, all entries cleared on reset.
module alu_regfile
  import alu_issue_pkg::*;
#(
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int REG_COUNT = REG_COUNT_DEF,
  localparam int REG_AW    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra_idx,
  input  logic [REG_AW-1:0] rb_idx,
  input  logic [REG_AW-1:0] dbg_idx,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [REG_COUNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

  assign ra_data  = regs[ra_idx];
  assign rb_data  = regs[rb_idx];
  assign dbg_data = regs[dbg_idx];

endmodule

// File: rtl/alu_operand_issue.sv
// Issue/writeback stage around the arithmetic unit: IDLE accepts and registers
// operands, ISSUE lets the unit settle, WB writes G/C back. Optional ZERO_FLAG_EN.
module alu_operand_issue
  import alu_issue_pkg::*;
#(
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int REG_COUNT = REG_COUNT_DEF,
  parameter  int SEL_W     = SEL_W_DEF,
  localparam int REG_AW    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [SEL_W-1:0]  instr_sel,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_ra,
  input  logic [REG_AW-1:0] instr_rb,
  input  logic              instr_usec,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_g,
  input  logic              alu_cout,
  output logic              done,
  output logic              c_flag,
  input  logic [REG_AW-1:0] rd_dbg_idx,
  output logic [DATA_W-1:0] rd_dbg_data
`ifdef ZERO_FLAG_EN
  ,
  output logic              z_flag
`endif
);

  state_e            state, state_nxt;
  logic              accept;
  logic              wb;
  logic [REG_AW-1:0] rd_p0;
  logic [DATA_W-1:0] ra_data, rb_data;

  alu_regfile #(
    .DATA_W    (DATA_W),
    .REG_COUNT (REG_COUNT)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra_idx   (instr_ra),
    .rb_idx   (instr_rb),
    .dbg_idx  (rd_dbg_idx),
    .wr_en    (wb),
    .wr_idx   (rd_p0),
    .wr_data  (alu_g),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .dbg_data (rd_dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (instr_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE);
    done        = (state == WB);
    accept      = instr_valid && (state == IDLE);
    wb          = (state == WB);
  end

  // Accept boundary: operands are sampled here, so a same-instruction rd hazard sees the old value
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_cin <= 1'b0;
      alu_sel <= '0;
      rd_p0   <= '0;
    end else if (accept) begin
      alu_a   <= ra_data;
      alu_b   <= rb_data;
      alu_cin <= instr_usec & c_flag;
      alu_sel <= instr_sel;
      rd_p0   <= instr_rd;
    end
  end

  // Writeback boundary: carry-out lands only in the flag
  always_ff @(posedge clk) begin
    if (rst)     c_flag <= 1'b0;
    else if (wb) c_flag <= alu_cout;
  end

`ifdef ZERO_FLAG_EN
  function automatic logic is_zero(input logic [DATA_W-1:0] v);
    return (v == '0);
  endfunction

  always_ff @(posedge clk) begin
    if (rst)     z_flag <= 1'b0;
    else if (wb) z_flag <= is_zero(alu_g);
  end
`endif

endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue with a behavioural arithmetic unit as partner and
// an array-based reference model of the register file and flags.
module tb_alu_operand_issue;

  localparam int DW = 4;
  localparam int RC = 4;
  localparam int AW = 2;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [SW-1:0] instr_sel;
  logic [AW-1:0] instr_rd, instr_ra, instr_rb;
  logic          instr_usec;
  logic [DW-1:0] alu_a, alu_b;
  logic          alu_cin;
  logic [SW-1:0] alu_sel;
  logic [DW-1:0] alu_g;
  logic          alu_cout;
  logic          done;
  logic          c_flag;
  logic [AW-1:0] rd_dbg_idx;
  logic [DW-1:0] rd_dbg_data;
`ifdef ZERO_FLAG_EN
  logic          z_flag;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int acc_cnt     = 0;

  int mreg [RC];
  int mc;
  int mz;

  always #5 clk = ~clk;

  alu_operand_issue #(.DATA_W(DW), .REG_COUNT(RC), .SEL_W(SW)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_sel   (instr_sel),
    .instr_rd    (instr_rd),
    .instr_ra    (instr_ra),
    .instr_rb    (instr_rb),
    .instr_usec  (instr_usec),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_cin     (alu_cin),
    .alu_sel     (alu_sel),
    .alu_g       (alu_g),
    .alu_cout    (alu_cout),
    .done        (done),
    .c_flag      (c_flag),
    .rd_dbg_idx  (rd_dbg_idx),
    .rd_dbg_data (rd_dbg_data)
`ifdef ZERO_FLAG_EN
    ,
    .z_flag      (z_flag)
`endif
  );

  // Arithmetic unit partner: G = A + {0, B, ~B, 1111}[sel] + C_in
  logic [DW-1:0] au_y;
  logic [DW:0]   au_sum;
  always_comb begin
    case (alu_sel)
      2'b00:   au_y = '0;
      2'b01:   au_y = alu_b;
      2'b10:   au_y = ~alu_b;
      default: au_y = '1;
    endcase
    au_sum = {1'b0, alu_a} + {1'b0, au_y} + {{DW{1'b0}}, alu_cin};
  end
  assign alu_g    = au_sum[DW-1:0];
  assign alu_cout = au_sum[DW];

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (instr_valid && instr_ready) acc_cnt <= acc_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < RC; i++) mreg[i] = 0;
    mc = 0;
    mz = 0;
  endfunction

  function automatic void model_exec(input int sel, input int rd, input int a, input int b,
                                     input int cin);
    int y, sum;
    y   = (sel == 0) ? 0 : (sel == 1) ? b : (sel == 2) ? (15 - b) : 15;
    sum = a + y + cin;
    mreg[rd] = sum % 16;
    mc = (sum > 15) ? 1 : 0;
    mz = ((sum % 16) == 0) ? 1 : 0;
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < RC; i++) begin
      rd_dbg_idx = AW'(i);
      @(negedge clk);
      check(tag, 32'(rd_dbg_data), mreg[i]);
    end
    @(posedge clk); #1;
  endtask

  // Starts and ends 1 ns after a rising edge with the stage idle
  task automatic do_op(input int sel, input int rd, input int ra, input int rb,
                       input int usec, input int gap);
    int a, b, cin;
    repeat (gap) begin @(posedge clk); #1; end
    check("ready_idle", 32'(instr_ready), 1);
    a = mreg[ra];
    b = mreg[rb];
    cin = (usec != 0) ? mc : 0;
    instr_valid = 1'b1;
    instr_sel   = sel[1:0];
    instr_rd    = rd[1:0];
    instr_ra    = ra[1:0];
    instr_rb    = rb[1:0];
    instr_usec  = usec[0];
    rd_dbg_idx  = rd[1:0];
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr_sel   = SW'($urandom);
    instr_rd    = AW'($urandom);
    instr_ra    = AW'($urandom);
    instr_rb    = AW'($urandom);
    instr_usec  = 1'($urandom);
    check("issue_a", 32'(alu_a), a);
    check("issue_b", 32'(alu_b), b);
    check("issue_sel", 32'(alu_sel), sel);
    check("issue_cin", 32'(alu_cin), cin);
    check("issue_ready", 32'(instr_ready), 0);
    check("issue_done", 32'(done), 0);
    @(posedge clk); #1;
    check("wb_done", 32'(done), 1);
    check("wb_ready", 32'(instr_ready), 0);
    check("wb_dbg_old", 32'(rd_dbg_data), mreg[rd]);
    @(posedge clk); #1;
    model_exec(sel, rd, a, b, cin);
    check("post_done", 32'(done), 0);
    check("post_ready", 32'(instr_ready), 1);
    check("post_cflag", 32'(c_flag), mc);
    check("post_rd", 32'(rd_dbg_data), mreg[rd]);
    check("hold_a", 32'(alu_a), a);
`ifdef ZERO_FLAG_EN
    check("post_zflag", 32'(z_flag), mz);
`endif
  endtask

  // Any value v: R[r] = R[r] + ~R[r] = F, then decrement 15-v times
  task automatic load_reg(input int r, input int v);
    do_op(2, r, r, r, 0, 0);
    repeat (15 - v) do_op(3, r, r, r, 0, 0);
  endtask

  initial begin
    int d0;
    int ready_exp [6];
    rst = 1'b1;
    instr_valid = 1'b0;
    instr_sel = '0; instr_rd = '0; instr_ra = '0; instr_rb = '0; instr_usec = 1'b0;
    rd_dbg_idx = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_ready", 32'(instr_ready), 1);
    check("rst_done", 32'(done), 0);
    check("rst_cflag", 32'(c_flag), 0);
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_alu_b", 32'(alu_b), 0);
    check("rst_alu_cin", 32'(alu_cin), 0);
    check("rst_alu_sel", 32'(alu_sel), 0);
    check_regs("rst_reg");

    // Add: R1=3, R2=5, R3 = R1 + R2
    load_reg(1, 3);
    load_reg(2, 5);
    do_op(1, 3, 1, 2, 0, 0);
    check("add_r3", 32'(rd_dbg_data), 8);
    check("add_cflag", 32'(c_flag), 0);

    // Carry chain: R2=1, R1=F, R0 = F+1 -> 0 carry 1; then R3 = F+1+1
    load_reg(2, 1);
    load_reg(1, 15);
    do_op(1, 0, 1, 2, 0, 1);
    check("carry_r0", 32'(rd_dbg_data), 0);
    check("carry_cflag", 32'(c_flag), 1);
`ifdef ZERO_FLAG_EN
    check("zero_set", 32'(z_flag), 1);
`endif
    do_op(1, 3, 1, 2, 1, 0);
    check("chain_cin", 32'(alu_cin), 1);
    check("chain_r3", 32'(rd_dbg_data), 1);
`ifdef ZERO_FLAG_EN
    check("zero_clr", 32'(z_flag), 0);
`endif

    // Hazard: rd=ra=rb=1 reads old R1
    load_reg(1, 7);
    do_op(1, 1, 1, 1, 0, 0);
    check("hazard_r1", 32'(rd_dbg_data), 14);
    do_op(0, 2, 1, 0, 0, 0);
    check("hazard_next_a", 32'(alu_a), 14);

    // Backpressure: valid held for 6 edges -> two accepts, two done pulses
    ready_exp = '{0, 0, 1, 0, 0, 1};
    d0 = done_cnt + acc_cnt * 1000;
    instr_valid = 1'b1; instr_sel = 2'b01; instr_rd = 2'd2; instr_ra = 2'd2;
    instr_rb = 2'd3; instr_usec = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("bp_ready", 32'(instr_ready), ready_exp[k]);
    end
    instr_valid = 1'b0;
    check("bp_counts", done_cnt + acc_cnt * 1000 - d0, 2002);
    model_exec(1, 2, mreg[2], mreg[3], 0);
    model_exec(1, 2, mreg[2], mreg[3], 0);
    check("bp_cflag", 32'(c_flag), mc);
    check_regs("bp_reg");

    // Randomized instruction stream against the model
    for (int n = 0; n < 30; n++) begin
      do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
    check_regs("rand_reg");

    // Reset mid-ISSUE aborts the instruction
    load_reg(3, 9);
    d0 = done_cnt;
    instr_valid = 1'b1; instr_sel = 2'b01; instr_rd = 2'd1; instr_ra = 2'd3;
    instr_rb = 2'd3; instr_usec = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_done1", 32'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_done2", 32'(done), 0);
    @(posedge clk); #1;
    model_reset();
    check("rst_mid_pulses", done_cnt - d0, 0);
    check("rst_mid_ready", 32'(instr_ready), 1);
    check("rst_mid_cflag", 32'(c_flag), 0);
    check("rst_mid_alu_a", 32'(alu_a), 0);
    check_regs("rst_mid_reg");
    do_op(2, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
